// File: rtl/counter_ctrl_pkg.sv
// Shared types and helpers for the front-panel counter step sequencer.
// Holds the FSM state and direction enums plus the repeat timer width helper.
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } dir_t;

    // Timer only ever holds reload values (cycles - 1), so clog2 of the larger count is enough.
    function automatic int timer_w(input int delay_cyc, input int rate_cyc);
        int max_cyc;
        max_cyc = (delay_cyc > rate_cyc) ? delay_cyc : rate_cyc;
        return (max_cyc < 2) ? 1 : $clog2(max_cyc);
    endfunction

    // Pressing both buttons at once is treated the same as pressing neither.
    function automatic dir_t decode_dir(input logic up_btn, input logic down_btn);
        dir_t dir;
        if (up_btn && !down_btn) begin
            dir = UP;
        end else if (down_btn && !up_btn) begin
            dir = DOWN;
        end else begin
            dir = NONE;
        end
        return dir;
    endfunction

endpackage

// File: rtl/repeat_timer.sv
// Down-counter for the hold-delay and auto-repeat intervals.
// Load has priority over decrement; the count parks at zero.
module repeat_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/counter_step_sequencer.sv
// Turns level button inputs into step/load strobes for the up/down/load counter.
// Optional build macro SATURATE_EN stops steps at the counter's end values.
//
// state  | meaning
// IDLE   | no button run active; a new press steps immediately
// DELAY  | first step issued, waiting for the hold delay to expire
// REPEAT | auto-repeating at the repeat rate while the button is held
module counter_step_sequencer
    import counter_ctrl_pkg::*;
#(
    parameter int BITS      = 8,
    parameter int DELAY_CYC = 50_000_000,
    parameter int RATE_CYC  = 10_000_000
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            up_btn,
    input  logic            down_btn,
    input  logic            load_req,
    input  logic [BITS-1:0] load_val,
    input  logic [BITS-1:0] q,
    output logic            cnt_enable,
    output logic            cnt_up,
    output logic            cnt_load,
    output logic [BITS-1:0] cnt_d,
    output logic            repeating
);

    localparam int TIMER_W = timer_w(DELAY_CYC, RATE_CYC);
    localparam logic [TIMER_W-1:0] DELAY_RELOAD = TIMER_W'(DELAY_CYC - 1);
    localparam logic [TIMER_W-1:0] RATE_RELOAD  = TIMER_W'(RATE_CYC - 1);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_DELAY  = DELAY;
    localparam logic [1:0] S_REPEAT = REPEAT;

    logic [1:0]         state;
    logic [1:0]         state_next;
    dir_t               run_dir;
    dir_t               run_dir_next;
    dir_t               req_dir;
    logic               load_prev;
    logic               load_rise;
    logic               step;
    logic               step_up;
    logic               step_ok;
    logic               sat_block;
    logic               tmr_load;
    logic               tmr_dec;
    logic               tmr_zero;
    logic [TIMER_W-1:0] tmr_load_val;

    assign req_dir   = decode_dir(up_btn, down_btn);
    assign load_rise = load_req & ~load_prev;

    always_comb begin
        state_next   = state;
        run_dir_next = run_dir;
        step         = 1'b0;
        step_up      = cnt_up;
        tmr_load     = 1'b0;
        tmr_load_val = DELAY_RELOAD;
        tmr_dec      = 1'b0;

        case (state)
            S_IDLE: begin
                if (req_dir != NONE) begin
                    step         = 1'b1;
                    step_up      = (req_dir == UP);
                    tmr_load     = 1'b1;
                    tmr_load_val = DELAY_RELOAD;
                    run_dir_next = req_dir;
                    state_next   = S_DELAY;
                end
            end
            S_DELAY, S_REPEAT: begin
                // Release or a direction change ends the run; the new direction starts from IDLE.
                if (req_dir != run_dir) begin
                    state_next = S_IDLE;
                end else if (tmr_zero) begin
                    step         = 1'b1;
                    step_up      = (run_dir == UP);
                    tmr_load     = 1'b1;
                    tmr_load_val = RATE_RELOAD;
                    state_next   = S_REPEAT;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // A load pre-empts whatever the run was about to do.
        if (load_rise) begin
            state_next = S_IDLE;
            step       = 1'b0;
            tmr_load   = 1'b0;
            tmr_dec    = 1'b0;
        end
    end

`ifdef SATURATE_EN
    // Timer and FSM keep running; only the strobe is held back at the end values.
    assign sat_block = step_up ? (&q) : (q == '0);
`else
    logic unused_q;
    assign sat_block = 1'b0;
    assign unused_q  = ^q;
`endif

    assign step_ok = step & ~sat_block;

    repeat_timer #(
        .W (TIMER_W)
    ) u_repeat_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            run_dir    <= NONE;
            load_prev  <= 1'b0;
            cnt_enable <= 1'b0;
            cnt_load   <= 1'b0;
            cnt_up     <= 1'b1;
            cnt_d      <= '0;
            repeating  <= 1'b0;
        end else begin
            state      <= state_next;
            run_dir    <= run_dir_next;
            load_prev  <= load_req;
            cnt_enable <= load_rise | step_ok;
            cnt_load   <= load_rise;
            if (load_rise) begin
                cnt_d <= load_val;
            end
            if (step_ok) begin
                cnt_up <= step_up;
            end
            repeating  <= (state_next == S_REPEAT);
        end
    end

endmodule

// File: tb/tb_counter_step_sequencer.sv
// Self-checking bench for counter_step_sequencer (DELAY_CYC=4, RATE_CYC=2, BITS=8).
// Expected outputs come from a hold-age model of the button run plus a shadow counter for q.
module tb_counter_step_sequencer;

    localparam int BITS      = 8;
    localparam int DELAY_CYC = 4;
    localparam int RATE_CYC  = 2;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            up_btn;
    logic            down_btn;
    logic            load_req;
    logic [BITS-1:0] load_val;
    logic [BITS-1:0] q;
    logic            cnt_enable;
    logic            cnt_up;
    logic            cnt_load;
    logic [BITS-1:0] cnt_d;
    logic            repeating;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state: a button run is described only by its direction and age in cycles.
    bit              m_en, m_up, m_load, m_rep, m_load_prev;
    bit              run_active, run_up;
    int              run_age;
    logic [BITS-1:0] m_d;
    logic [BITS-1:0] m_q = '0;
    bit              q_force = 1'b0;
    logic [BITS-1:0] q_val = '0;

    counter_step_sequencer #(
        .BITS      (BITS),
        .DELAY_CYC (DELAY_CYC),
        .RATE_CYC  (RATE_CYC)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .up_btn     (up_btn),
        .down_btn   (down_btn),
        .load_req   (load_req),
        .load_val   (load_val),
        .q          (q),
        .cnt_enable (cnt_enable),
        .cnt_up     (cnt_up),
        .cnt_load   (cnt_load),
        .cnt_d      (cnt_d),
        .repeating  (repeating)
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        bit              old_en, old_load, old_up, lr, step, allowed;
        logic [BITS-1:0] old_d;
        int              req;
        old_en   = m_en;
        old_load = m_load;
        old_up   = m_up;
        old_d    = m_d;
        if (!reset_n) begin
            m_en = 0; m_load = 0; m_up = 1; m_rep = 0; m_d = '0;
            m_load_prev = 0; run_active = 0; run_age = 0;
        end else begin
            m_en   = 0;
            m_load = 0;
            step   = 0;
            lr     = load_req && !m_load_prev;
            m_load_prev = load_req;
            req = (up_btn && !down_btn) ? 1 : ((down_btn && !up_btn) ? 2 : 0);
            if (lr) begin
                m_en = 1; m_load = 1; m_d = load_val; run_active = 0;
            end else if (!run_active) begin
                if (req != 0) begin
                    run_active = 1; run_up = (req == 1); run_age = 0; step = 1;
                end
            end else if (req == 0 || ((req == 1) != run_up)) begin
                run_active = 0;
            end else begin
                run_age++;
                if (run_age >= DELAY_CYC && ((run_age - DELAY_CYC) % RATE_CYC) == 0) step = 1;
            end
            allowed = 1;
`ifdef SATURATE_EN
            if ((run_up && q == 8'hFF) || (!run_up && q == 8'h00)) allowed = 0;
`endif
            if (step && allowed) begin
                m_en = 1; m_up = run_up;
            end
            m_rep = run_active && (run_age >= DELAY_CYC);
        end
        // The counter acts on the strobes that were visible before this edge.
        if (old_en) m_q = old_load ? old_d : (old_up ? m_q + 8'd1 : m_q - 8'd1);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        q = q_force ? q_val : m_q;
    endtask

    task automatic test_reset();
        reset_n = 0; up_btn = 0; down_btn = 0; load_req = 0; load_val = '0; q = '0;
        tick();
        tick();
        if ({cnt_enable, cnt_up, cnt_load, repeating, cnt_d} !== 12'h400) begin
            errors++;
            $display("FAIL reset_values cycle %0d: got %03h want %03h", cyc,
                     {cnt_enable, cnt_up, cnt_load, repeating, cnt_d}, 12'h400);
        end
        checks++;
        reset_n = 1;
        tick();
        if ({cnt_enable, cnt_up, cnt_load, repeating, cnt_d} !== {m_en, m_up, m_load, m_rep, m_d}) begin
            errors++;
            $display("FAIL reset_release cycle %0d: got %03h want %03h", cyc,
                     {cnt_enable, cnt_up, cnt_load, repeating, cnt_d}, {m_en, m_up, m_load, m_rep, m_d});
        end
        checks++;
    endtask

    task automatic test_single_pulse();
        int n_en = 0;
        up_btn = 1;
        tick();
        if (cnt_enable !== 1'b1 || cnt_up !== 1'b1 || cnt_load !== 1'b0) begin
            errors++;
            $display("FAIL pulse_first_step cycle %0d: got en=%b up=%b ld=%b want en=1 up=1 ld=0",
                     cyc, cnt_enable, cnt_up, cnt_load);
        end
        checks++;
        n_en += int'(cnt_enable === 1'b1);
        up_btn = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_en += int'(cnt_enable === 1'b1);
            if ({cnt_enable, cnt_up, cnt_load, repeating, cnt_d} !== {m_en, m_up, m_load, m_rep, m_d}) begin
                errors++;
                $display("FAIL pulse_model cycle %0d: got %03h want %03h", cyc,
                         {cnt_enable, cnt_up, cnt_load, repeating, cnt_d}, {m_en, m_up, m_load, m_rep, m_d});
            end
            checks++;
        end
        if (n_en != 1) begin
            errors++;
            $display("FAIL pulse_count: got %0d strobes want 1", n_en);
        end
        checks++;
    endtask

    task automatic test_hold_repeat();
        logic [12:0] step_mask;
        step_mask = 13'h0AA2;
        up_btn = 1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (cnt_enable !== step_mask[i] || (step_mask[i] && cnt_up !== 1'b1)) begin
                errors++;
                $display("FAIL hold_step rel %0d: got en=%b up=%b want en=%b up=1", i, cnt_enable, cnt_up, step_mask[i]);
            end
            checks++;
            if (repeating !== (i >= 5)) begin
                errors++;
                $display("FAIL hold_repeating rel %0d: got %b want %b", i, repeating, (i >= 5));
            end
            checks++;
            if ({cnt_enable, cnt_up, cnt_load, repeating, cnt_d} !== {m_en, m_up, m_load, m_rep, m_d}) begin
                errors++;
                $display("FAIL hold_model cycle %0d: got %03h want %03h", cyc,
                         {cnt_enable, cnt_up, cnt_load, repeating, cnt_d}, {m_en, m_up, m_load, m_rep, m_d});
            end
            checks++;
        end
        up_btn = 0;
        tick();
        if (cnt_enable !== 1'b0 || repeating !== 1'b0) begin
            errors++;
            $display("FAIL hold_release cycle %0d: got en=%b rep=%b want en=0 rep=0", cyc, cnt_enable, repeating);
        end
        checks++;
        tick();
    endtask

    task automatic test_dir_conflict();
        down_btn = 1;
        tick();
        if (cnt_enable !== 1'b1 || cnt_up !== 1'b0) begin
            errors++;
            $display("FAIL conflict_down_step cycle %0d: got en=%b up=%b want en=1 up=0", cyc, cnt_enable, cnt_up);
        end
        checks++;
        tick();
        tick();
        up_btn = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (cnt_enable !== 1'b0 || cnt_up !== 1'b0 || repeating !== 1'b0) begin
                errors++;
                $display("FAIL conflict_quiet cycle %0d: got en=%b up=%b rep=%b want 0 0 0", cyc, cnt_enable, cnt_up, repeating);
            end
            checks++;
        end
        // Dropping up leaves down alone; an immediate step proves the FSM sat in IDLE.
        up_btn = 0;
        tick();
        if (cnt_enable !== 1'b1 || cnt_up !== 1'b0) begin
            errors++;
            $display("FAIL conflict_idle_restart cycle %0d: got en=%b up=%b want en=1 up=0", cyc, cnt_enable, cnt_up);
        end
        checks++;
        down_btn = 0;
        tick();
        tick();
    endtask

    task automatic test_load_in_repeat();
        up_btn = 1;
        for (int i = 0; i < 6; i++) tick();
        load_req = 1;
        load_val = 8'h2A;
        tick();
        if ({cnt_enable, cnt_load, repeating, cnt_d} !== {1'b1, 1'b1, 1'b0, 8'h2A}) begin
            errors++;
            $display("FAIL load_strobe cycle %0d: got en=%b ld=%b rep=%b d=%02h want en=1 ld=1 rep=0 d=2a",
                     cyc, cnt_enable, cnt_load, repeating, cnt_d);
        end
        checks++;
        load_val = 8'h55;
        tick();
        if (cnt_enable !== 1'b1 || cnt_load !== 1'b0 || cnt_up !== 1'b1) begin
            errors++;
            $display("FAIL load_restart cycle %0d: got en=%b ld=%b up=%b want en=1 ld=0 up=1", cyc, cnt_enable, cnt_load, cnt_up);
        end
        checks++;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cnt_load !== 1'b0) begin
                errors++;
                $display("FAIL load_held cycle %0d: got ld=%b want 0", cyc, cnt_load);
            end
            checks++;
            if ({cnt_enable, cnt_up, cnt_load, repeating, cnt_d} !== {m_en, m_up, m_load, m_rep, m_d}) begin
                errors++;
                $display("FAIL load_model cycle %0d: got %03h want %03h", cyc,
                         {cnt_enable, cnt_up, cnt_load, repeating, cnt_d}, {m_en, m_up, m_load, m_rep, m_d});
            end
            checks++;
        end
        up_btn = 0;
        load_req = 0;
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic test_reset_mid_repeat();
        up_btn = 1;
        for (int i = 0; i < 7; i++) tick();
        if (repeating !== 1'b1) begin
            errors++;
            $display("FAIL midrst_in_repeat cycle %0d: got rep=%b want 1", cyc, repeating);
        end
        checks++;
        reset_n = 0;
        tick();
        if ({cnt_enable, cnt_up, cnt_load, repeating, cnt_d} !== 12'h400) begin
            errors++;
            $display("FAIL midrst_values cycle %0d: got %03h want %03h", cyc,
                     {cnt_enable, cnt_up, cnt_load, repeating, cnt_d}, 12'h400);
        end
        checks++;
        reset_n = 1;
        tick();
        if (cnt_enable !== 1'b1 || cnt_up !== 1'b1 || repeating !== 1'b0) begin
            errors++;
            $display("FAIL midrst_restep cycle %0d: got en=%b up=%b rep=%b want 1 1 0", cyc, cnt_enable, cnt_up, repeating);
        end
        checks++;
        up_btn = 0;
        tick();
        tick();
    endtask

    task automatic test_saturation();
        int n_up = 0;
        int n_dn = 0;
        int exp_n;
`ifdef SATURATE_EN
        exp_n = 0;
`else
        exp_n = 5;
`endif
        q_force = 1;
        q_val = 8'hFF;
        q = q_val;
        up_btn = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_up += int'(cnt_enable === 1'b1);
            if ({cnt_enable, cnt_up, cnt_load, repeating, cnt_d} !== {m_en, m_up, m_load, m_rep, m_d}) begin
                errors++;
                $display("FAIL sat_up_model cycle %0d: got %03h want %03h", cyc,
                         {cnt_enable, cnt_up, cnt_load, repeating, cnt_d}, {m_en, m_up, m_load, m_rep, m_d});
            end
            checks++;
        end
        up_btn = 0;
        tick();
        tick();
        q_val = 8'h00;
        q = q_val;
        down_btn = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_dn += int'(cnt_enable === 1'b1);
            if ({cnt_enable, cnt_up, cnt_load, repeating, cnt_d} !== {m_en, m_up, m_load, m_rep, m_d}) begin
                errors++;
                $display("FAIL sat_down_model cycle %0d: got %03h want %03h", cyc,
                         {cnt_enable, cnt_up, cnt_load, repeating, cnt_d}, {m_en, m_up, m_load, m_rep, m_d});
            end
            checks++;
        end
        down_btn = 0;
        tick();
        tick();
        if (n_up != exp_n || n_dn != exp_n) begin
            errors++;
            $display("FAIL sat_counts: got up=%0d down=%0d want %0d each", n_up, n_dn, exp_n);
        end
        checks++;
        q_force = 0;
        q = m_q;
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(7) == 0) up_btn = 1'($urandom);
            if ($urandom_range(7) == 0) down_btn = 1'($urandom);
            if ($urandom_range(15) == 0) load_req = ~load_req;
            load_val = 8'($urandom);
            reset_n = ($urandom_range(199) != 0);
            tick();
            if ({cnt_enable, cnt_up, cnt_load, repeating, cnt_d} !== {m_en, m_up, m_load, m_rep, m_d}) begin
                errors++;
                $display("FAIL random_model cycle %0d: got %03h want %03h", cyc,
                         {cnt_enable, cnt_up, cnt_load, repeating, cnt_d}, {m_en, m_up, m_load, m_rep, m_d});
            end
            checks++;
        end
        reset_n = 1;
        up_btn = 0;
        down_btn = 0;
        load_req = 0;
    endtask

    initial begin
        test_reset();
        test_single_pulse();
        test_hold_repeat();
        test_dir_conflict();
        test_load_in_repeat();
        test_reset_mid_repeat();
        test_saturation();
        test_random(3000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
